// File: rtl/noc_local_port_mux.sv
// rtl/noc_local_port_mux.sv - round-robin, packet-atomic, credit-gated mux onto a router local port
module noc_local_port_mux #(
    parameter int NUM_CHANNELS      = 4,
    parameter int FLIT_WIDTH        = 32,
    parameter int DEST_WIDTH        = 4,
    parameter int FLIT_BUFFER_DEPTH = 2,
    localparam int PW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int CW = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                               clk_noc,
    input  logic                               rst_n,
    input  logic [NUM_CHANNELS-1:0]            in_valid,
    output logic [NUM_CHANNELS-1:0]            in_ready,
    input  logic [NUM_CHANNELS*FLIT_WIDTH-1:0] in_data,
    input  logic [NUM_CHANNELS*DEST_WIDTH-1:0] in_dest,
    input  logic [NUM_CHANNELS-1:0]            in_is_tail,
    output logic [FLIT_WIDTH-1:0]              data_out,
    output logic [DEST_WIDTH-1:0]              dest_out,
    output logic                               is_tail_out,
    output logic                               send_out,
    input  logic                               credit_in,
    output logic [PW-1:0]                      active_channel,
    output logic                               locked,
    output logic                               credit_err
);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t                r_state;
    logic [PW-1:0]         r_rr_ptr;
    logic [PW-1:0]         r_active;
    logic [CW-1:0]         r_credits;
    logic [FLIT_WIDTH-1:0] r_data;
    logic [DEST_WIDTH-1:0] r_dest;
    logic                  r_tail;
    logic                  r_send;
    logic                  r_locked;
    logic                  r_err;

    logic [PW:0]   w_idx;
    logic [PW-1:0] w_grant;
    logic          w_grant_found;
    logic [PW-1:0] w_sel;
    logic          w_sel_ok;
    logic          w_can;
    logic          w_accept;
    logic          w_tail;
    logic [PW-1:0] w_next_ptr;
    logic          w_full;

    // Search from the round-robin pointer upward, wrapping at NUM_CHANNELS.
    always_comb begin
        w_grant       = '0;
        w_grant_found = 1'b0;
        w_idx         = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(NUM_CHANNELS))
                w_idx = w_idx - (PW+1)'(NUM_CHANNELS);
            if (!w_grant_found && in_valid[w_idx[PW-1:0]]) begin
                w_grant       = w_idx[PW-1:0];
                w_grant_found = 1'b1;
            end
        end
    end

    assign w_sel      = (r_state == ST_LOCKED) ? r_active : w_grant;
    assign w_sel_ok   = (r_state == ST_LOCKED) || w_grant_found;
    assign w_can      = rst_n && (r_credits != '0) && w_sel_ok;
    assign in_ready   = w_can ? (NUM_CHANNELS'(1) << w_sel) : '0;
    assign w_accept   = w_can && in_valid[w_sel];
    assign w_tail     = in_is_tail[w_sel];
    assign w_next_ptr = (w_sel == PW'(NUM_CHANNELS - 1)) ? '0 : w_sel + PW'(1);
    assign w_full     = (r_credits == CW'(FLIT_BUFFER_DEPTH));

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_active  <= '0;
            r_credits <= CW'(FLIT_BUFFER_DEPTH);
            r_data    <= '0;
            r_dest    <= '0;
            r_tail    <= 1'b0;
            r_send    <= 1'b0;
            r_locked  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_send <= w_accept;
            if (w_accept) begin
                r_data <= in_data[int'(w_sel)*FLIT_WIDTH +: FLIT_WIDTH];
                r_dest <= in_dest[int'(w_sel)*DEST_WIDTH +: DEST_WIDTH];
                r_tail <= w_tail;
            end

            // Accept and return in the same cycle cancel out.
            if (w_accept && !credit_in) begin
                r_credits <= r_credits - CW'(1);
            end else if (!w_accept && credit_in) begin
                if (w_full)
                    r_err <= 1'b1;
                else
                    r_credits <= r_credits + CW'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_tail) begin
                            r_rr_ptr <= w_next_ptr;
                        end else begin
                            r_state  <= ST_LOCKED;
                            r_active <= w_sel;
                            r_locked <= 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_accept && w_tail) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= w_next_ptr;
                        r_locked <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign data_out       = r_data;
    assign dest_out       = r_dest;
    assign is_tail_out    = r_tail;
    assign send_out       = r_send;
    assign active_channel = r_active;
    assign locked         = r_locked;
    assign credit_err     = r_err;

endmodule

// File: tb/tb_noc_local_port_mux.sv
// tb/tb_noc_local_port_mux.sv - directed vector bench for noc_local_port_mux
module tb_noc_local_port_mux;

    localparam int N  = 4;
    localparam int FW = 32;
    localparam int DW = 4;

    logic            clk_noc = 1'b0;
    logic            rst_n;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*FW-1:0] in_data;
    logic [N*DW-1:0] in_dest;
    logic [N-1:0]    in_is_tail;
    logic [FW-1:0]   data_out;
    logic [DW-1:0]   dest_out;
    logic            is_tail_out;
    logic            send_out;
    logic            credit_in;
    logic [1:0]      active_channel;
    logic            locked;
    logic            credit_err;

    noc_local_port_mux #(
        .NUM_CHANNELS(N), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(2)
    ) dut (
        .clk_noc(clk_noc), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_dest(in_dest), .in_is_tail(in_is_tail),
        .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
        .send_out(send_out), .credit_in(credit_in),
        .active_channel(active_channel), .locked(locked), .credit_err(credit_err)
    );

    always #5 clk_noc = ~clk_noc;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] tail;
        logic       cr;
        logic [3:0] ready;
        logic       send;
        int         ch;
        logic       tail_o;
        logic       lock;
        logic [1:0] act;
        logic       err;
    } vec_t;

    vec_t vecs[26];
    int   checks = 0;
    int   errors = 0;
    logic [FW-1:0] exp_data;
    logic [DW-1:0] exp_dest;

    function automatic vec_t mkv(logic [3:0] valid, logic [3:0] tail, logic cr,
                                 logic [3:0] ready, logic send, int ch,
                                 logic tail_o, logic lock, logic [1:0] act, logic err);
        vec_t v;
        v.valid = valid; v.tail = tail; v.cr = cr; v.ready = ready; v.send = send;
        v.ch = ch; v.tail_o = tail_o; v.lock = lock; v.act = act; v.err = err;
        return v;
    endfunction

    function automatic logic [FW-1:0] mk(int v, int ch);
        return 32'hC0DE_0000 | FW'(v << 4) | FW'(ch);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input int v, input logic [3:0] valid, input logic [3:0] tail, input logic cr);
        in_valid   = valid;
        in_is_tail = tail;
        credit_in  = cr;
        for (int c = 0; c < N; c++) begin
            in_data[c*FW +: FW] = mk(v, c);
            in_dest[c*DW +: DW] = DW'(c);
        end
    endtask

    task automatic check_outs(input int idx, input logic send, input logic tail_o,
                              input logic lock, input logic [1:0] act, input logic err);
        chk("send_out", idx, 64'(send_out), 64'(send));
        chk("data_out", idx, 64'(data_out), 64'(exp_data));
        chk("dest_out", idx, 64'(dest_out), 64'(exp_dest));
        chk("is_tail_out", idx, 64'(is_tail_out), 64'(tail_o));
        chk("locked", idx, 64'(locked), 64'(lock));
        chk("active_channel", idx, 64'(active_channel), 64'(act));
        chk("credit_err", idx, 64'(credit_err), 64'(err));
    endtask

    initial begin
        // fairness, single-flit, credits returned every cycle
        vecs[0]  = mkv(4'hF, 4'hF, 1, 4'b0001, 1, 0, 1, 0, 0, 0);
        vecs[1]  = mkv(4'hF, 4'hF, 1, 4'b0010, 1, 1, 1, 0, 0, 0);
        vecs[2]  = mkv(4'hF, 4'hF, 1, 4'b0100, 1, 2, 1, 0, 0, 0);
        vecs[3]  = mkv(4'hF, 4'hF, 1, 4'b1000, 1, 3, 1, 0, 0, 0);
        vecs[4]  = mkv(4'hF, 4'hF, 1, 4'b0001, 1, 0, 1, 0, 0, 0);
        vecs[5]  = mkv(4'h0, 4'h0, 0, 4'b0000, 0, 0, 1, 0, 0, 0);
        // ch1 three-flit packet while ch0/ch2 also request
        vecs[6]  = mkv(4'h7, 4'h5, 1, 4'b0010, 1, 1, 0, 1, 1, 0);
        vecs[7]  = mkv(4'h7, 4'h5, 1, 4'b0010, 1, 1, 0, 1, 1, 0);
        vecs[8]  = mkv(4'h7, 4'h7, 1, 4'b0010, 1, 1, 1, 0, 1, 0);
        vecs[9]  = mkv(4'h7, 4'h7, 1, 4'b0100, 1, 2, 1, 0, 1, 0);
        vecs[10] = mkv(4'h0, 4'h0, 0, 4'b0000, 0, 0, 1, 0, 1, 0);
        // credit stall with no returns, then a single return
        vecs[11] = mkv(4'h8, 4'h8, 0, 4'b1000, 1, 3, 1, 0, 1, 0);
        vecs[12] = mkv(4'h8, 4'h8, 0, 4'b1000, 1, 3, 1, 0, 1, 0);
        vecs[13] = mkv(4'h8, 4'h8, 0, 4'b0000, 0, 0, 1, 0, 1, 0);
        vecs[14] = mkv(4'h8, 4'h8, 1, 4'b0000, 0, 0, 1, 0, 1, 0);
        vecs[15] = mkv(4'h8, 4'h8, 0, 4'b1000, 1, 3, 1, 0, 1, 0);
        vecs[16] = mkv(4'h8, 4'h8, 0, 4'b0000, 0, 0, 1, 0, 1, 0);
        // accept + return at credits=1
        vecs[17] = mkv(4'h0, 4'h0, 1, 4'b0000, 0, 0, 1, 0, 1, 0);
        vecs[18] = mkv(4'h8, 4'h8, 1, 4'b1000, 1, 3, 1, 0, 1, 0);
        vecs[19] = mkv(4'h8, 4'h8, 0, 4'b1000, 1, 3, 1, 0, 1, 0);
        // refill then overflow; sticky error
        vecs[20] = mkv(4'h0, 4'h0, 1, 4'b0000, 0, 0, 1, 0, 1, 0);
        vecs[21] = mkv(4'h0, 4'h0, 1, 4'b0000, 0, 0, 1, 0, 1, 0);
        vecs[22] = mkv(4'h0, 4'h0, 1, 4'b0000, 0, 0, 1, 0, 1, 1);
        vecs[23] = mkv(4'hF, 4'hF, 0, 4'b0001, 1, 0, 1, 0, 1, 1);
        vecs[24] = mkv(4'h0, 4'h0, 1, 4'b0000, 0, 0, 1, 0, 1, 1);
        vecs[25] = mkv(4'h0, 4'h0, 0, 4'b0000, 0, 0, 1, 0, 1, 1);

        rst_n    = 1'b0;
        drive(0, 4'hF, 4'hF, 1'b0);
        exp_data = '0;
        exp_dest = '0;
        #1;
        chk("reset_in_ready", 0, 64'(in_ready), 64'h0);
        check_outs(0, 0, 0, 0, 2'd0, 0);
        repeat (2) @(posedge clk_noc);
        @(negedge clk_noc);
        drive(0, 4'h0, 4'h0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            @(negedge clk_noc);
            drive(i, vecs[i].valid, vecs[i].tail, vecs[i].cr);
            #1;
            chk("in_ready", i, 64'(in_ready), 64'(vecs[i].ready));
            @(posedge clk_noc);
            #1;
            if (vecs[i].send) begin
                exp_data = mk(i, vecs[i].ch);
                exp_dest = DW'(vecs[i].ch);
            end
            check_outs(i, vecs[i].send, vecs[i].tail_o, vecs[i].lock, vecs[i].act, vecs[i].err);
        end

        // head flit on ch3 locks the port
        @(negedge clk_noc);
        drive(100, 4'h8, 4'h0, 1'b1);
        #1 chk("seq_ready", 100, 64'(in_ready), 64'h8);
        @(posedge clk_noc); #1;
        exp_data = mk(100, 3); exp_dest = 4'd3;
        check_outs(100, 1, 0, 1, 2'd3, 1);

        // ch3 stalls mid-packet; others must stay blocked
        @(negedge clk_noc);
        drive(101, 4'h7, 4'h0, 1'b0);
        #1 chk("seq_ready", 101, 64'(in_ready), 64'h8);
        @(posedge clk_noc); #1;
        check_outs(101, 0, 0, 1, 2'd3, 1);

        @(negedge clk_noc);
        drive(102, 4'hF, 4'h0, 1'b1);
        #1 chk("seq_ready", 102, 64'(in_ready), 64'h8);
        @(posedge clk_noc); #1;
        exp_data = mk(102, 3);
        check_outs(102, 1, 0, 1, 2'd3, 1);

        // asynchronous reset while locked
        @(negedge clk_noc);
        drive(103, 4'hF, 4'hF, 1'b0);
        rst_n = 1'b0;
        #1;
        exp_data = '0; exp_dest = '0;
        chk("rst_ready", 103, 64'(in_ready), 64'h0);
        check_outs(103, 0, 0, 0, 2'd0, 0);
        @(negedge clk_noc);
        rst_n = 1'b1;
        drive(104, 4'hF, 4'hF, 1'b0);
        #1 chk("post_rst_ready", 104, 64'(in_ready), 64'h1);
        @(posedge clk_noc); #1;
        exp_data = mk(104, 0); exp_dest = 4'd0;
        check_outs(104, 1, 1, 0, 2'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_local_port_mux.md
NOC_LOCAL_PORT_MUX -- requirements
Module: noc_local_port_mux

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4: number of local injection channels sharing one router local input port (range 1..16).
REQ-002 SHALL have parameter FLIT_WIDTH, default 32: flit payload width.
REQ-003 SHALL have parameter DEST_WIDTH, default 4: destination field width ({tid, tdest}).
REQ-004 SHALL have parameter FLIT_BUFFER_DEPTH, default 2: router input buffer depth, which is also the initial credit count (range 1..64).
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk_noc input 1 (the only clock), then rst_n input 1 (asynchronous assert, active-low).
REQ-006 SHALL have port in_valid, input, NUM_CHANNELS: per-channel flit valid.
REQ-007 SHALL have port in_ready, output, NUM_CHANNELS: per-channel flit accept.
REQ-008 SHALL have port in_data, input, NUM_CHANNELS x FLIT_WIDTH: per-channel flit payload.
REQ-009 SHALL have port in_dest, input, NUM_CHANNELS x DEST_WIDTH: per-channel destination.
REQ-010 SHALL have port in_is_tail, input, NUM_CHANNELS: per-channel last-flit-of-packet marker.
REQ-011 SHALL have ports data_out (output, FLIT_WIDTH), dest_out (output, DEST_WIDTH), is_tail_out (output, 1) and send_out (output, 1): flit to the router local port.
REQ-012 SHALL have port credit_in, input, 1: one credit returned by the router per pulse.
REQ-013 SHALL have port active_channel, output, max(1,$clog2(NUM_CHANNELS)): channel currently holding the lock.
REQ-014 SHALL have port locked, output, 1: a packet is in progress.
REQ-015 SHALL have port credit_err, output, 1: sticky flag set by credit overflow.

Function
REQ-016 SHALL keep a credit counter of width $clog2(FLIT_BUFFER_DEPTH+1): decrement by 1 on each accepted flit; increment by 1 on credit_in; hold when both occur in the same cycle.
REQ-017 SHALL, when credit_in arrives with credits == FLIT_BUFFER_DEPTH and no simultaneous accept, leave the count unchanged and set credit_err; credit_err clears only on reset.
REQ-018 SHALL run an FSM with states IDLE and LOCKED, plus a round-robin pointer rr_ptr.
REQ-019 SHALL, in IDLE, grant combinationally the first channel i with in_valid[i]=1, searching from rr_ptr upward with wrap-around.
REQ-020 SHALL assert in_ready only for the granted channel (IDLE) or the locked channel (LOCKED), and only when credits > 0; all other in_ready bits SHALL be 0.
REQ-021 SHALL define an accept as in_valid[g] & in_ready[g]; at most one accept per cycle.
REQ-022 SHALL, on an IDLE accept with in_is_tail=0, go to LOCKED, set active_channel=g and set locked=1.
REQ-023 SHALL, on an IDLE accept with in_is_tail=1 (single-flit packet), stay in IDLE and set rr_ptr=(g+1) mod NUM_CHANNELS.
REQ-024 SHALL, in LOCKED, ignore all other channels and never interleave packets.
REQ-025 SHALL, on a LOCKED tail accept, return to IDLE, set rr_ptr=(active_channel+1) mod NUM_CHANNELS and clear locked.
REQ-026 SHALL keep LOCKED with no timeout when the locked channel drops in_valid mid-packet.
REQ-027 SHALL register data_out, dest_out and is_tail_out from the accepted flit with latency 1 cycle, and pulse send_out=1 for exactly 1 cycle per accept.
REQ-028 SHALL hold data_out, dest_out and is_tail_out at their last values when no accept occurs.
REQ-029 SHALL, at credits == 0, deassert in_ready while leaving state and rr_ptr unchanged; a credit_in in that cycle makes in_ready available the following cycle, never combinationally.
REQ-030 SHALL reduce to a pass-through with credit tracking when NUM_CHANNELS=1: rr_ptr constant 0, active_channel 0.

Reset
REQ-031 SHALL, while rst_n=0, immediately force: state IDLE, rr_ptr 0, credits FLIT_BUFFER_DEPTH, send_out 0, data_out 0, dest_out 0, is_tail_out 0, active_channel 0, locked 0, credit_err 0, in_ready 0.
REQ-032 SHALL, on reset asserted mid-packet, drop the partial packet; the first accept after release SHALL be treated as a head flit in IDLE.

Verification
REQ-033 SHALL cover arbitration fairness: NUM_CHANNELS=4, all channels continuously valid with single-flit packets, credits returned each cycle -> grant order 0,1,2,3,0,... with send_out every cycle after the first.
REQ-034 SHALL cover packet atomicity: ch1 sends a 3-flit packet while ch0 and ch2 are valid -> three consecutive ch1 flits on data_out, is_tail_out=1 on the third, then ch2 granted.
REQ-035 SHALL cover credit stall: FLIT_BUFFER_DEPTH=2, no credit_in -> exactly 2 sends, in_ready=0 thereafter; one credit_in -> exactly one more send, 2 cycles after the credit pulse.
REQ-036 SHALL cover simultaneous events: accept and credit_in in the same cycle at credits=1 -> credits stays 1 and the next flit is accepted the next cycle.
REQ-037 SHALL cover credit overflow: credit_in at credits=2 (full) -> credits stays 2, credit_err=1 and remains 1 until rst_n=0.
REQ-038 SHALL cover reset mid-packet: rst_n low for 1 cycle while LOCKED on ch3 -> all outputs return to reset values; after release, ch0 is granted first.
